// File: rtl/cia_pipe_adder.sv
// Pipelined carry-increment adder/subtractor: one BLOCK-bit segment is resolved per stage,
// with a single global advance enable shared by every stage and a valid/ready handshake at both ends.
module cia_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             sub,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             outValid,
    input  logic             outReady
);
    localparam int NSTG = WIDTH / BLOCK;

    logic adv;

    assign adv     = !outValid || outReady;
    assign inReady = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int SRCW = WIDTH - k * BLOCK;   // operand bits not yet consumed
        localparam int SUMW = (k + 1) * BLOCK;     // sum bits resolved so far

        logic [SRCW-1:0]  a_src;
        logic [SRCW-1:0]  b_src;
        logic             sub_src;
        logic             c_src;
        logic             v_src;
        logic [SUMW-1:0]  s_next;
        logic [BLOCK-1:0] a_seg;
        logic [BLOCK-1:0] b_seg;
        logic [BLOCK-1:0] seg;
        logic [BLOCK:0]   seg_add;
        logic [BLOCK:0]   seg_inc;
        logic             c_next;
        logic             v;
        logic             c;
        logic [SUMW-1:0]  s;

        if (k == 0) begin : g_head
            assign a_src   = inA;
            assign b_src   = inB;
            assign sub_src = sub;
            assign c_src   = sub ? 1'b1 : cin;
            assign v_src   = inValid;
            assign s_next  = seg;
        end else begin : g_body
            assign a_src   = g_stg[k-1].g_fwd.a;
            assign b_src   = g_stg[k-1].g_fwd.b;
            assign sub_src = g_stg[k-1].g_fwd.sb;
            assign c_src   = g_stg[k-1].c;
            assign v_src   = g_stg[k-1].v;
            assign s_next  = {seg, g_stg[k-1].s};
        end

        // Segment add with carry-in 0, then increment by the carry from the stage below.
        assign a_seg   = a_src[BLOCK-1:0];
        assign b_seg   = b_src[BLOCK-1:0] ^ {BLOCK{sub_src}};
        assign seg_add = {1'b0, a_seg} + {1'b0, b_seg};
        assign seg_inc = {1'b0, seg_add[BLOCK-1:0]} + {{BLOCK{1'b0}}, c_src};
        assign seg     = seg_inc[BLOCK-1:0];
        // NOTE: the add and the increment can never both carry out, so OR-ing them is exact.
        assign c_next  = seg_add[BLOCK] | seg_inc[BLOCK];

        // NOTE: data registers are reset too (not only valid bits) so outputs are never X.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
            end else if (adv) begin
                v <= v_src;
                c <= c_next;
                s <= s_next;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [SRCW-BLOCK-1:0] a;
            logic [SRCW-BLOCK-1:0] b;
            logic                  sb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a  <= '0;
                    b  <= '0;
                    sb <= 1'b0;
                end else if (adv) begin
                    a  <= a_src[SRCW-1:BLOCK];
                    b  <= b_src[SRCW-1:BLOCK];
                    sb <= sub_src;
                end
            end
        end else begin : g_tail
            logic ov;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov <= 1'b0;
                end else if (adv) begin
                    ov <= (a_seg[BLOCK-1] == b_seg[BLOCK-1]) && (seg[BLOCK-1] != a_seg[BLOCK-1]);
                end
            end
        end
    end

    assign sum      = g_stg[NSTG-1].s;
    assign cout     = g_stg[NSTG-1].c;
    assign ovf      = g_stg[NSTG-1].g_tail.ov;
    assign outValid = g_stg[NSTG-1].v;

endmodule

// File: tb/tb_cia_pipe_adder.sv
// Bench for cia_pipe_adder: four parameterisations side by side, an arithmetic reference model
// with a per-instance delay queue, directed corner cases, a stall stream, a mid-cycle reset and random traffic.
module tb_cia_pipe_adder;
    localparam int N = 4;

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        c;
        logic        o;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ia   [N];
    logic [31:0] ib   [N];
    logic        icin [N];
    logic        isub [N];
    logic        ivld [N];
    logic        ordy [N];
    logic [31:0] osum [N];
    logic        ocout[N];
    logic        oovf [N];
    logic        ovld [N];
    logic        irdy [N];

    ent_t q [N][$];
    int   acc [N];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic int wd(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int bk(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lat(input int i);
        return wd(i) / bk(i);
    endfunction

    function automatic logic [31:0] msk(input int i);
        return (wd(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd(i)) - 32'd1);
    endfunction

    // Plain two's-complement arithmetic: A + (sub ? ~B + 1 : B + cin).
    function automatic ent_t model(input int i, input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        logic [63:0] be;
        logic [63:0] full;
        ent_t        e;
        int          w;
        w     = wd(i);
        be    = s ? {32'd0, (~b) & msk(i)} : {32'd0, b};
        full  = {32'd0, a} + be + {63'd0, (s ? 1'b1 : c)};
        e.v   = 1'b1;
        e.s   = full[31:0] & msk(i);
        e.c   = full[w];
        e.o   = (a[w-1] == be[w-1]) && (e.s[w-1] != a[w-1]);
        return e;
    endfunction

    function automatic logic mvalid(input int i);
        return (q[i].size() == lat(i)) && q[i][0].v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    logic [15:0] s0;
    logic [7:0]  s1, s2;
    logic [31:0] s3;
    logic        c0, c1, c2, c3, o0, o1, o2, o3, v0, v1, v2, v3, r0, r1, r2, r3;

    cia_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .inA(ia[0][15:0]), .inB(ib[0][15:0]), .cin(icin[0]), .sub(isub[0]),
        .inValid(ivld[0]), .inReady(r0), .sum(s0), .cout(c0), .ovf(o0), .outValid(v0), .outReady(ordy[0]));
    cia_pipe_adder #(.WIDTH(8), .BLOCK(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .inA(ia[1][7:0]), .inB(ib[1][7:0]), .cin(icin[1]), .sub(isub[1]),
        .inValid(ivld[1]), .inReady(r1), .sum(s1), .cout(c1), .ovf(o1), .outValid(v1), .outReady(ordy[1]));
    cia_pipe_adder #(.WIDTH(8), .BLOCK(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .inA(ia[2][7:0]), .inB(ib[2][7:0]), .cin(icin[2]), .sub(isub[2]),
        .inValid(ivld[2]), .inReady(r2), .sum(s2), .cout(c2), .ovf(o2), .outValid(v2), .outReady(ordy[2]));
    cia_pipe_adder #(.WIDTH(32), .BLOCK(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .inA(ia[3]), .inB(ib[3]), .cin(icin[3]), .sub(isub[3]),
        .inValid(ivld[3]), .inReady(r3), .sum(s3), .cout(c3), .ovf(o3), .outValid(v3), .outReady(ordy[3]));

    assign osum[0] = {16'd0, s0};
    assign osum[1] = {24'd0, s1};
    assign osum[2] = {24'd0, s2};
    assign osum[3] = s3;
    assign ocout[0] = c0; assign ocout[1] = c1; assign ocout[2] = c2; assign ocout[3] = c3;
    assign oovf[0]  = o0; assign oovf[1]  = o1; assign oovf[2]  = o2; assign oovf[3]  = o3;
    assign ovld[0]  = v0; assign ovld[1]  = v1; assign ovld[2]  = v2; assign ovld[3]  = v3;
    assign irdy[0]  = r0; assign irdy[1]  = r1; assign irdy[2]  = r2; assign irdy[3]  = r3;

    // Model update: every advancing edge pushes either the accepted op or a bubble;
    // the output shows whatever was pushed lat-1 advances ago.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                q[i].delete();
            end else if (!mvalid(i) || ordy[i]) begin
                if (ivld[i]) begin
                    q[i].push_back(model(i, ia[i], ib[i], icin[i], isub[i]));
                    acc[i]++;
                end else begin
                    q[i].push_back(ent_t'(0));
                end
                if (q[i].size() > lat(i)) void'(q[i].pop_front());
            end
        end
    end

    // Compare process: outputs against the model on every cycle, away from the rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic ev;
            ev = rst_n && mvalid(i);
            check($sformatf("out_valid[%0d]", i), {63'd0, ovld[i]}, {63'd0, ev});
            check($sformatf("in_ready[%0d]", i), {63'd0, irdy[i]}, {63'd0, (!ev || ordy[i] || !rst_n)});
            check($sformatf("no_x[%0d]", i), {63'd0, $isunknown({osum[i], ocout[i], oovf[i]})}, 64'd0);
            if (ev) begin
                check($sformatf("sum[%0d]", i), {32'd0, osum[i]}, {32'd0, q[i][0].s});
                check($sformatf("cout[%0d]", i), {63'd0, ocout[i]}, {63'd0, q[i][0].c});
                check($sformatf("ovf[%0d]", i), {63'd0, oovf[i]}, {63'd0, q[i][0].o});
            end
        end
    end

    // One op on instance i; pins latency and the literal result.
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input logic [31:0] es, input logic ec, input logic eo,
                          input string nm);
        @(negedge clk); #1;
        ia[i] = a; ib[i] = b; icin[i] = c; isub[i] = s; ivld[i] = 1'b1; ordy[i] = 1'b1;
        for (int k = 1; k <= lat(i); k++) begin
            @(negedge clk); #1;
            if (k == 1) ivld[i] = 1'b0;
            if (k == lat(i) - 1) check({nm, "_early"}, {63'd0, ovld[i]}, 64'd0);
            if (k == lat(i)) begin
                check({nm, "_valid"}, {63'd0, ovld[i]}, 64'd1);
                check({nm, "_sum"}, {32'd0, osum[i]}, {32'd0, es});
                check({nm, "_cout"}, {63'd0, ocout[i]}, {63'd0, ec});
                check({nm, "_ovf"}, {63'd0, oovf[i]}, {63'd0, eo});
            end
        end
    endtask

    initial begin
        int idx, got, cyc;
        logic done;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            ia[i] = '0; ib[i] = '0; icin[i] = 1'b0; isub[i] = 1'b0; ivld[i] = 1'b0; ordy[i] = 1'b1;
            acc[i] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", {63'd0, v0}, 64'd0);
        check("reset_sum", {48'd0, s0}, 64'd0);
        check("reset_cout_ovf", {62'd0, c0, o0}, 64'd0);
        check("reset_in_ready", {63'd0, r0}, 64'd1);
        #1 rst_n = 1'b1;

        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "add_ffff_1");
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "add_7fff_1");
        run_op(0, 32'h00FF, 32'h0000, 1'b1, 1'b0, 32'h0100, 1'b0, 1'b0, "add_00ff_cin");
        run_op(0, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, "sub_5_7");
        run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub_8000_1");
        run_op(1, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "w8b8_add");
        run_op(2, 32'h0080, 32'h0001, 1'b0, 1'b1, 32'h007F, 1'b1, 1'b1, "w8b2_sub");
        run_op(3, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "w32b4_add");

        // Stream i+i for i=1..8 with the sink stalled in cycles 5-7.
        idx = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
            ordy[0] = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) begin
                ia[0] = idx + 1; ib[0] = idx + 1; icin[0] = 1'b0; isub[0] = 1'b0; ivld[0] = 1'b1;
            end else begin
                ivld[0] = 1'b0;
            end
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_in_ready", {63'd0, r0}, 64'd0);
                check("stall_valid", {63'd0, v0}, 64'd1);
                check("stall_hold_sum", {48'd0, s0}, 64'd2);
            end
            if (v0 && ordy[0]) begin
                check("stream_sum", {48'd0, s0}, 64'(2 * (got + 1)));
                got++;
            end
            if (ivld[0] && r0) idx++;
        end
        check("stream_count", 64'(got), 64'd8);
        @(negedge clk); #1;
        ivld[0] = 1'b0; ordy[0] = 1'b1;
        check("stream_no_dup", {63'd0, v0}, 64'd0);

        // Three ops in flight, then an asynchronous reset between clock edges.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            ia[0] = 32'h100 + j; ib[0] = 32'h1; isub[0] = 1'b0; icin[0] = 1'b0; ivld[0] = 1'b1;
        end
        @(negedge clk); #1;
        ivld[0] = 1'b0;
        check("inflight_not_out", {63'd0, v0}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, v0}, 64'd0);
        check("async_rst_sum", {48'd0, s0}, 64'd0);
        check("async_rst_cout_ovf", {62'd0, c0, o0}, 64'd0);
        check("async_rst_in_ready", {63'd0, r0}, 64'd1);
        @(negedge clk); #1;
        ia[0] = 32'h1234; ib[0] = 32'h1111; ivld[0] = 1'b1;
        @(negedge clk); #1;
        ivld[0] = 1'b0;
        #1 rst_n = 1'b1;
        run_op(0, 32'h1234, 32'h4321, 1'b1, 1'b0, 32'h5556, 1'b0, 1'b0, "post_rst_add");

        // Random traffic on all four instances.
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) acc[i] = 0;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 40000) begin
            @(negedge clk); #1;
            cyc++;
            done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] < 10000) done = 1'b0;
                ordy[i] = ($urandom_range(0, 3) != 0);
                ivld[i] = (acc[i] < 10000) && ($urandom_range(0, 4) != 0);
                ia[i]   = $urandom() & msk(i);
                ib[i]   = $urandom() & msk(i);
                icin[i] = 1'($urandom_range(0, 1));
                isub[i] = 1'($urandom_range(0, 1));
            end
        end
        check("random_budget", {63'd0, done}, 64'd1);
        for (int i = 0; i < N; i++) begin
            ivld[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (12) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) check($sformatf("drained[%0d]", i), {63'd0, ovld[i]}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cia_pipe_adder.md
CIA_PIPE_ADDER -- requirements
Module: cia_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter BLOCK, default 4: bits per carry-increment segment.
REQ-003 WIDTH SHALL be an integer multiple of BLOCK, with WIDTH >= BLOCK >= 1; NSTG = WIDTH/BLOCK.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: sole clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port inA, input, WIDTH bits: operand A.
REQ-008 Port inB, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 Port sub, input, 1 bit: mode select, 0 = add, 1 = subtract.
REQ-011 Port inValid, input, 1 bit: operands valid this cycle.
REQ-012 Port inReady, output, 1 bit: block can accept this cycle.
REQ-013 Port sum, output, WIDTH bits: result.
REQ-014 Port cout, output, 1 bit: carry-out of the MSB.
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 Port outValid, output, 1 bit: sum, cout and ovf are valid.
REQ-017 Port outReady, input, 1 bit: downstream accepts the result.

Function
REQ-018 An input transfer SHALL occur on a rising edge where inValid=1 and inReady=1.
REQ-019 An output transfer SHALL occur on a rising edge where outValid=1 and outReady=1.
REQ-020 Add mode SHALL compute {cout,sum} = inA + inB + cin, modulo 2^(WIDTH+1).
REQ-021 Subtract mode SHALL compute {cout,sum} = inA + ~inB + 1 and ignore cin; cout=1 means no borrow.
REQ-022 ovf SHALL be 1 iff the MSBs of A and effective B are equal and the sum MSB differs from them.
REQ-023 The datapath SHALL be an NSTG-stage pipeline, with one BLOCK-bit segment resolved per stage.
REQ-024 Each stage SHALL add its segment with carry-in 0, then increment the segment by the carry registered from the previous stage.
REQ-025 Stage k SHALL carry the unresolved upper operand bits and the sub flag forward with its data.
REQ-026 There SHALL be one global advance enable: adv = !outValid || outReady; inReady = adv (combinational).
REQ-027 When adv=1, every stage SHALL shift by one and stage 0 SHALL load (inValid && inReady).
REQ-028 When adv=0, all stage registers, including valid bits, SHALL hold.
REQ-029 With no stall, the result SHALL appear on outValid exactly NSTG cycles after the input transfer edge.
REQ-030 Throughput SHALL be one operation per cycle while outReady=1.
REQ-031 Bubbles SHALL propagate and are not collapsed.
REQ-032 Results SHALL leave strictly in acceptance order, with none dropped or duplicated.
REQ-033 sum, cout and ovf SHALL be stable while outValid=1 and outReady=0.
REQ-034 When outValid=0, sum, cout and ovf values are don't-care but SHALL NOT be X after reset.
REQ-035 With NSTG=1, the block SHALL degenerate to a single registered ripple-carry segment with latency 1.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear all stage valid bits, so outValid=0 immediately.
REQ-037 rst_n=0 SHALL asynchronously clear all data registers to 0, so sum=0, cout=0 and ovf=0.
REQ-038 An operation in flight when rst_n asserts SHALL be discarded, with no output produced for it.
REQ-039 During reset, inReady SHALL be 1, since adv=1 because outValid=0; transfers are ignored while rst_n=0.
REQ-040 The first input accepted after rst_n deasserts SHALL obey REQ-029.

Verification (WIDTH=16, BLOCK=4, latency 4)
REQ-041 Add 0xFFFF+0x0001, cin=0, outReady=1 -> 4 cycles later: sum=0x0000, cout=1, ovf=0.
REQ-042 Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then add 0x00FF+0x0000, cin=1 -> sum=0x0100, cout=0.
REQ-043 Sub 0x0005-0x0007 (cin=1, ignored) -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-044 Stream 8 back-to-back adds i+i, i=1..8, with outReady=0 for cycles 5-7 -> inReady=0 and outputs held during the stall; results 2,4,...,16 delivered in order, exactly once each.
REQ-045 Assert rst_n=0 mid-cycle with 3 operations in flight -> outValid drops without waiting for clk; after release, no stale result appears and a new op's result arrives at latency 4.
REQ-046 Parameter sweep: (WIDTH,BLOCK) = (8,8), (8,2), (32,4), with 10k random operations compared against a reference model -> zero mismatches, and latency equals WIDTH/BLOCK.
